prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/prefetch_unit.sv | 146 ++++++++++++++
 tb/tb_prefetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction prefetch path.
//   fetch_entry_t : one buffered instruction together with the PC it was fetched from
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0) used by decode
//   PC_ALIGN_MASK : clears the byte-offset bits of a fetch address
//   align_pc()    : applies PC_ALIGN_MASK to an arbitrary target address
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Instructions are always word aligned, so the low two bits of any
  // redirect target carry no information and are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO holding fetched instructions in registers. The
// oldest entry is always visible on head_data (no read latency), which lets
// decode see the instruction in the same cycle it is counted as present.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous clear; overrides push and pop in that cycle
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : drop the head entry (ignored while empty)
//   head_data   : oldest entry (undefined contents while empty)
//   count       : number of valid entries, 0..DEPTH
//   full, empty : count == DEPTH / count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A flush wins over everything else in its cycle; a pop is only honoured
  // when there is something to pop so the pointers can never cross.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  // Storage array. It needs no reset because nothing reads an entry
  // before it has been written, and the top masks head_data while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit
// Instruction prefetcher: owns the fetch PC, issues word requests to
// instruction memory, buffers the returned words with their PCs and hands
// them to decode. Redirects flush the buffer and silently discard every
// response belonging to requests issued before the redirect.
// Ports:
//   clk, rst                                     : clock, async active-high reset
//   imem_req_valid/ready, imem_req_addr          : fetch request channel
//   imem_rsp_valid, imem_rsp_data                : in-order response channel
//   redirect_valid, redirect_pc                  : branch/jump target from execute
//   instr_valid/ready, instr_data, instr_pc      : instruction stream to decode
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          req_fire;
  logic [31:0]   target_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Every request in flight has a reserved FIFO slot, so a live response can
  // always be pushed without any backpressure on the memory side.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign target_pc = align_pc(redirect_pc);

  // Responses are accepted unconditionally; only those not already marked
  // stale (and not arriving under a redirect) become instructions.
  assign fifo_push  = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign instr_valid = !fifo_empty && !redirect_valid;
  assign fifo_pop    = instr_valid && instr_ready;

  // While the buffer is empty the outputs show a clean zero word and the PC
  // the next instruction will carry, which also gives the reset values.
  assign instr_data = fifo_empty ? 32'h0 : head_entry.instr;
  assign instr_pc   = fifo_empty ? rsp_pc : head_entry.pc;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fetch address: jumps to the aligned target on a redirect, otherwise
  // advances one word per accepted request and wraps at the top of memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= target_pc;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC tag for the next live response. It tracks fetch_pc in lockstep but
  // only advances when an instruction is actually buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= target_pc;
    end else if (fifo_push) begin
      rsp_pc <= rsp_pc + 32'd4;
    end
  end

  // Requests in flight, stale or not. Redirects block acceptance, so the
  // increment and decrement sources never need redirect qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stale-response counter. On a redirect everything in flight becomes
  // stale; a response landing in the redirect cycle is already discarded
  // there, so it is taken out of the count. Older pending drops are still
  // inside outstanding, which is why a plain reload is enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= imem_rsp_valid ? (outstanding - CW'(1)) : outstanding;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // The credit scheme must make a push into a full buffer impossible.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rst) !(fifo_push && fifo_full)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit
// Self-checking bench for prefetch_unit. A behavioural memory answers the
// DUT's requests in order after a programmable latency. The reference keeps
// the set of instructions decode should see as a queue of addresses: each
// request is tagged with the redirect epoch it was issued in, and a response
// becomes an instruction only if its epoch is still current.
module tb_prefetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  prefetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  mem_req_t    rsp_q[$];
  logic [31:0] buf_q[$];
  int          cyc;
  int          epoch;
  int          mem_lat;
  logic [31:0] exp_fetch;
  int          n_checks;
  int          n_fail;
  int          accepts;
  int          delivers;
  logic [31:0] acc_addr[3];
  int          first_req_cyc;
  int          first_val_cyc;
  logic        prev_valid;
  logic        prev_ready;
  logic [31:0] prev_addr;
  logic        want_first;
  logic [31:0] want_pc;
  logic        first_seen;
  logic        found;

  // Memory contents: a scrambled function of the address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reset asserted wherever the caller currently is in the cycle; outputs
  // must fall immediately. Memory and reference are reset with the DUT.
  task automatic applyReset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = NOP_INSTR;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    checkOutput("rst_req_valid",   32'(imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid),    32'd0);
    checkOutput("rst_req_addr",    imem_req_addr,       RST_PC);
    checkOutput("rst_instr_data",  instr_data,          32'd0);
    checkOutput("rst_instr_pc",    instr_pc,            RST_PC);
    repeat (2) @(posedge clk);
    rsp_q.delete();
    buf_q.delete();
    exp_fetch     = RST_PC;
    epoch++;
    cyc           = 0;
    accepts       = 0;
    delivers      = 0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    prev_valid    = 1'b0;
    want_first    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the settled
  // outputs, then advance memory and reference to the next rising edge.
  task automatic applyStimulus(input logic dec_rdy, input logic mem_rdy,
                               input logic redir, input logic [31:0] rpc);
    logic rsp_now;
    logic exp_rv;
    logic exp_iv;
    logic acc;
    @(negedge clk);
    instr_ready    = dec_rdy;
    imem_req_ready = mem_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp_now        = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? data_of(rsp_q[0].addr) : NOP_INSTR;
    #1;
    exp_rv = !redir && ((rsp_q.size() + buf_q.size()) < DEPTH);
    exp_iv = !redir && (buf_q.size() != 0);
    checkOutput("req_valid",   32'(imem_req_valid), 32'(exp_rv));
    checkOutput("instr_valid", 32'(instr_valid),    32'(exp_iv));
    if (imem_req_valid && exp_rv)
      checkOutput("req_addr", imem_req_addr, exp_fetch);
    if (instr_valid && exp_iv) begin
      checkOutput("instr_pc",   instr_pc,   buf_q[0]);
      checkOutput("instr_data", instr_data, data_of(buf_q[0]));
    end
    if (prev_valid && !prev_ready && imem_req_valid && !redir)
      checkOutput("req_addr_stable", imem_req_addr, prev_addr);
    if (instr_valid && dec_rdy && want_first) begin
      checkOutput("first_after_redirect", instr_pc, want_pc);
      want_first = 1'b0;
      first_seen = 1'b1;
    end
    acc = imem_req_valid && mem_rdy;
    if (acc) begin
      if (accepts < 3) acc_addr[accepts] = imem_req_addr;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      accepts++;
    end
    if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (instr_valid && dec_rdy) delivers++;
    prev_valid = imem_req_valid;
    prev_ready = mem_rdy;
    prev_addr  = imem_req_addr;
    if (exp_iv && dec_rdy) void'(buf_q.pop_front());
    if (rsp_now) begin
      if (!redir && rsp_q[0].epoch == epoch) buf_q.push_back(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end
    if (redir) begin
      epoch++;
      buf_q.delete();
      exp_fetch = rpc & 32'hFFFF_FFFC;
    end else if (exp_rv && mem_rdy) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    if (acc) rsp_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat, epoch: epoch});
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    epoch      = 0;
    mem_lat    = 1;
    first_seen = 1'b0;
    rst        = 1'b0;
    #2;
    applyReset();

    // Streaming from reset across the 32-bit wrap with a 1-cycle memory.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("first_instr_latency", 32'(first_val_cyc - first_req_cyc), 32'd2);
    checkOutput("wrap_addr0", acc_addr[0], 32'hFFFF_FFF8);
    checkOutput("wrap_addr1", acc_addr[1], 32'hFFFF_FFFC);
    checkOutput("wrap_addr2", acc_addr[2], 32'h0000_0000);
    checkOutput("stream_deliveries", 32'(delivers), 32'd18);

    // Decode backpressure: credits cap the fetch-ahead at the buffer depth.
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_accepts", 32'(accepts), 32'd4);
    checkOutput("bp_req_valid_low", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_no_loss", 32'(delivers >= 8), 32'd1);

    // Redirect with three requests in flight at latency 3.
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_q.size() == 3) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("three_in_flight", 32'(found), 32'd1);
    first_seen = 1'b0;
    want_first = 1'b1;
    want_pc    = 32'h0000_0100;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirect_0x100_delivered", 32'(first_seen), 32'd1);

    // Redirect landing in the same cycle as a response, unaligned target.
    mem_lat = 2;
    found   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("rsp_with_redirect", 32'(found), 32'd1);
    first_seen = 1'b0;
    want_first = 1'b1;
    want_pc    = 32'h0000_0200;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("redir_req_addr",  imem_req_addr,       32'h0000_0200);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirect_0x200_delivered", 32'(first_seen), 32'd1);

    // Wrap from reset with random memory stalls and random decode readiness.
    mem_lat = 1;
    applyReset();
    for (int i = 0; i < 40; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'(($urandom % 3) != 0), 1'b0, 32'h0);
    checkOutput("stall_enough_accepts", 32'(accepts >= 3), 32'd1);
    checkOutput("stall_wrap_addr0", acc_addr[0], 32'hFFFF_FFF8);
    checkOutput("stall_wrap_addr1", acc_addr[1], 32'hFFFF_FFFC);
    checkOutput("stall_wrap_addr2", acc_addr[2], 32'h0000_0000);

    // Random traffic with varying latency and occasional redirects.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) mem_lat = int'($urandom_range(1, 4));
      applyStimulus(1'(($urandom % 4) != 0), 1'(($urandom % 4) != 0),
                    1'(($urandom % 20) == 0), $urandom);
    end

    // Asynchronous reset between clock edges while instructions are buffered.
    mem_lat = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("pre_reset_instr_valid", 32'(instr_valid), 32'd1);
    #2;
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("restart_addr", acc_addr[0], RST_PC);
    checkOutput("restart_first_req_cycle", 32'(first_req_cyc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
